// File: rtl/nexi_uart_wb_master.sv
// -----------------------------------------------------------------------------
// nexi_uart_wb_master
//
// Wishbone master that drives a single 32-bit UART register word. The word
// holds four byte lanes, each one selected by sel_o: RBR [31:24], THR [23:16],
// IER [15:8] and ISR [7:0].
//
// After reset the block writes IER_INIT to IER. After that it services the
// UART interrupt (an ISR read, then an RBR read when bit1 is set) and sends
// bytes offered on tx_data/tx_valid through THR. After a THR write it waits
// for ISR bit0 (TX done) before it accepts the next byte.
//
// Every bus cycle ends in RELEASE, which holds cyc/stb low until ack_i has
// dropped. A cycle that gets no ack within ACK_TIMEOUT strobe cycles is
// abandoned and sets the sticky bus_err_o flag.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   cyc_o, stb_o, we_o         Wishbone control
//   addr_o, data_o, sel_o      Wishbone address (always 0), write data, lanes
//   ack_i, data_i              Wishbone acknowledge and read data
//   irq_i                      UART interrupt, level sensitive
//   tx_data/tx_valid/tx_ready  byte-in stream; tx_ready marks consumption
//   rx_data/rx_valid/rx_ready  byte-out stream; rx_valid held until taken
//   bus_err_o                  sticky: an ack timeout has occurred
//   rx_overrun_o               sticky: an untaken rx byte was overwritten
// -----------------------------------------------------------------------------
module nexi_uart_wb_master #(
  parameter logic [7:0]  IER_INIT    = 8'h03,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [2:0]  addr_o,
  output logic [31:0] data_o,
  output logic [3:0]  sel_o,
  input  logic        ack_i,
  input  logic [31:0] data_i,
  input  logic        irq_i,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        bus_err_o,
  output logic        rx_overrun_o
);

  typedef enum logic [2:0] {INIT, IDLE, WR_THR, RD_ISR, RD_RBR, RELEASE} state_e;

  localparam int unsigned   CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_e        state_q, state_d;
  state_e        pend_q, pend_d;     // state to enter once RELEASE completes
  logic          bus_q;              // shared register behind cyc_o and stb_o
  logic [CW-1:0] cnt_q;              // strobe cycles elapsed without an ack
  logic          tx_busy_q;          // THR written, TX-done not yet seen
  logic          init_done_q;        // IER write acknowledged

  logic ack_hit, timeout, isr_ack, rx_load, rx_take;

  // These states drive a bus cycle.
  function automatic logic is_bus(input state_e s);
    return (s == INIT) || (s == WR_THR) || (s == RD_ISR) || (s == RD_RBR);
  endfunction

  assign ack_hit  = bus_q && ack_i;
  assign timeout  = bus_q && !ack_i && (cnt_q == CNT_LAST);
  assign isr_ack  = (state_q == RD_ISR) && ack_hit;
  assign rx_load  = (state_q == RD_RBR) && ack_hit;
  assign rx_take  = rx_valid && rx_ready;

  // The byte is consumed in the cycle the THR write is acknowledged. tx_busy
  // rises on that edge, so tx_ready and tx_busy are never high together.
  assign tx_ready = (state_q == WR_THR) && ack_hit;

  assign cyc_o  = bus_q;
  assign stb_o  = bus_q;
  assign addr_o = 3'b000;

  // Only the RBR lane and ISR bits 1:0 of the read data are used.
  logic unused_data;
  assign unused_data = ^data_i[23:2];

  // NOTE: every variable gets a default at the top of this block. Without it a
  // path that does not assign it would infer a latch.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      INIT, WR_THR, RD_ISR, RD_RBR: begin
        if (ack_hit) begin
          state_d = RELEASE;
          pend_d  = (state_q == RD_ISR && data_i[1]) ? RD_RBR : IDLE;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (!init_done_q)              state_d = INIT;   // retry a timed-out INIT
        else if (irq_i)                state_d = RD_ISR;
        else if (tx_valid && !tx_busy_q) state_d = WR_THR;
      end
      RELEASE: begin
        if (!ack_i) state_d = pend_q;
      end
      default: state_d = INIT;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments. Each flop then samples
  // the values from before the edge, whatever order the statements run in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= INIT;
      pend_q       <= IDLE;
      bus_q        <= 1'b0;
      cnt_q        <= '0;
      we_o         <= 1'b0;
      sel_o        <= 4'b0000;
      data_o       <= 32'h0;
      tx_busy_q    <= 1'b0;
      init_done_q  <= 1'b0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      bus_err_o    <= 1'b0;
      rx_overrun_o <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      bus_q   <= is_bus(state_d);
      cnt_q   <= (bus_q && !ack_hit && !timeout) ? cnt_q + CW'(1) : '0;

      // Load the bus fields only when a cycle starts. They then hold until the
      // cycle ends, so a change on tx_data cannot disturb a write in flight.
      if (!bus_q && is_bus(state_d)) begin
        case (state_d)
          INIT: begin
            we_o   <= 1'b1;
            sel_o  <= 4'b0010;
            data_o <= {16'h0000, IER_INIT, 8'h00};
          end
          WR_THR: begin
            we_o   <= 1'b1;
            sel_o  <= 4'b0100;
            data_o <= {8'h00, tx_data, 16'h0000};
          end
          RD_ISR: begin
            we_o   <= 1'b0;
            sel_o  <= 4'b0001;
            data_o <= 32'h0;
          end
          default: begin
            we_o   <= 1'b0;
            sel_o  <= 4'b1000;
            data_o <= 32'h0;
          end
        endcase
      end

      if (state_q == INIT && ack_hit) init_done_q <= 1'b1;

      if (tx_ready)                 tx_busy_q <= 1'b1;
      else if (isr_ack && data_i[0]) tx_busy_q <= 1'b0;

      if (timeout) bus_err_o <= 1'b1;

      // If a load and a take fall on the same edge, the new byte replaces the
      // one being taken, rx_valid stays high and there is no overrun.
      if (rx_load) begin
        rx_data  <= data_i[31:24];
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ready) rx_overrun_o <= 1'b1;
      end else if (rx_take) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nexi_uart_wb_master.sv
// -----------------------------------------------------------------------------
// tb_nexi_uart_wb_master
//
// Self-checking bench for nexi_uart_wb_master. A behavioural Wishbone slave
// models the UART's ISR and RBR lanes. Each bus cycle the master should issue
// is queued as it is stimulated. The slave pops and compares each entry when
// it acknowledges the matching cycle.
// -----------------------------------------------------------------------------
module tb_nexi_uart_wb_master;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] data;
  } bus_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cyc_o, stb_o, we_o;
  logic [2:0]  addr_o;
  logic [31:0] data_o;
  logic [3:0]  sel_o;
  logic        ack_i;
  logic [31:0] data_i;
  logic        irq_i;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        bus_err_o;
  logic        rx_overrun_o;

  nexi_uart_wb_master #(.IER_INIT(8'h03), .ACK_TIMEOUT(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cyc_o        (cyc_o),
    .stb_o        (stb_o),
    .we_o         (we_o),
    .addr_o       (addr_o),
    .data_o       (data_o),
    .sel_o        (sel_o),
    .ack_i        (ack_i),
    .data_i       (data_i),
    .irq_i        (irq_i),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .bus_err_o    (bus_err_o),
    .rx_overrun_o (rx_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_vec = 0;
  int   n_err = 0;
  int   txr_cnt = 0;     // tx_ready pulses seen
  int   exp_txr = 0;     // tx_ready pulses expected
  bus_t expq[$];
  logic mute = 1'b0;     // slave withholds ack while set
  logic [7:0] isr_m = 8'h00;
  logic [7:0] rbr_m = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic we, input logic [3:0] sel, input logic [31:0] data);
    bus_t e;
    e.we = we; e.sel = sel; e.data = data;
    expq.push_back(e);
  endtask

  task automatic raise_irq(input logic [7:0] isr, input logic [7:0] rbr);
    isr_m = isr;
    rbr_m = rbr;
    irq_i = 1'b1;
  endtask

  // Wait until every expected cycle has been seen and the bus is quiet.
  task automatic drain(input int budget);
    int n = 0;
    while ((expq.size() != 0 || cyc_o) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check("drain_queue", expq.size(), 0);
    check("drain_cyc", {31'b0, cyc_o}, 0);
    repeat (3) @(negedge clk_i);
  endtask

  // Wishbone slave. It acts just after each rising edge and acks for one cycle.
  initial begin
    bus_t e;
    ack_i  = 1'b0;
    data_i = 32'h0;
    forever begin
      @(posedge clk_i);
      #1;
      if (ack_i) begin
        ack_i = 1'b0;
        check("release_cyc", {31'b0, cyc_o}, 0);
      end else if (rst_ni && cyc_o && stb_o && !mute) begin
        ack_i = 1'b1;
        case (sel_o)
          4'b1000: data_i = {rbr_m, 24'h0};
          4'b0001: begin
            data_i = {24'h0, isr_m};
            isr_m  = 8'h00;
            irq_i  = 1'b0;
          end
          default: data_i = 32'h0;
        endcase
        check("cycle_expected", {31'b0, expq.size() != 0}, 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("we", {31'b0, we_o}, {31'b0, e.we});
          check("sel", {28'b0, sel_o}, {28'b0, e.sel});
          check("addr", {29'b0, addr_o}, 0);
          if (e.we) check("wdata", data_o, e.data);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (tx_ready) txr_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, len;
    rst_ni = 1'b0; irq_i = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset state
    check("rst_cyc", {31'b0, cyc_o}, 0);
    check("rst_stb", {31'b0, stb_o}, 0);
    check("rst_we", {31'b0, we_o}, 0);
    check("rst_sel", {28'b0, sel_o}, 0);
    check("rst_data", data_o, 0);
    check("rst_txr", {31'b0, tx_ready}, 0);
    check("rst_rx", {23'b0, rx_valid, rx_data}, 0);
    check("rst_flags", {30'b0, bus_err_o, rx_overrun_o}, 0);

    // IER write is the first cycle after release
    push(1'b1, 4'b0010, 32'h0000_0300);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("init_cyc", {31'b0, cyc_o}, 1);
    drain(50);

    // Single byte to THR
    tx_data = 8'h41; tx_valid = 1'b1;
    push(1'b1, 4'b0100, 32'h0041_0000);
    drain(50);
    exp_txr++;
    check("tx1_ready", txr_cnt, exp_txr);

    // Second byte waits for TX done
    tx_data = 8'h42;
    repeat (20) @(negedge clk_i);
    check("tx2_blocked", txr_cnt, exp_txr);
    raise_irq(8'h01, 8'h00);
    push(1'b0, 4'b0001, 32'h0);
    push(1'b1, 4'b0100, 32'h0042_0000);
    drain(80);
    exp_txr++;
    check("tx2_ready", txr_cnt, exp_txr);
    tx_valid = 1'b0;

    // Receive: ISR then RBR
    raise_irq(8'h02, 8'h5A);
    push(1'b0, 4'b0001, 32'h0);
    push(1'b0, 4'b1000, 32'h0);
    drain(80);
    check("rx1_data", {24'b0, rx_data}, 32'h5A);
    check("rx1_valid", {31'b0, rx_valid}, 1);
    check("rx1_ovr", {31'b0, rx_overrun_o}, 0);

    // Load on the same edge as a take: valid stays, no overrun
    raise_irq(8'h02, 8'h33);
    push(1'b0, 4'b0001, 32'h0);
    push(1'b0, 4'b1000, 32'h0);
    n = 0;
    while (!(ack_i && sel_o == 4'b1000) && n < 60) begin
      @(posedge clk_i); #2; n++;
    end
    check("rbr_ack_seen", {31'b0, n < 60}, 1);
    rx_ready = 1'b1;
    @(posedge clk_i); #2;
    rx_ready = 1'b0;
    drain(40);
    check("rx2_data", {24'b0, rx_data}, 32'h33);
    check("rx2_valid", {31'b0, rx_valid}, 1);
    check("rx2_ovr", {31'b0, rx_overrun_o}, 0);
    @(negedge clk_i); rx_ready = 1'b1;
    @(negedge clk_i); rx_ready = 1'b0;
    check("rx2_taken", {31'b0, rx_valid}, 0);

    // ISR read to clear tx_busy, then irq and tx_valid together
    raise_irq(8'h01, 8'h00);
    push(1'b0, 4'b0001, 32'h0);
    drain(50);
    rx_ready = 1'b1;
    raise_irq(8'h03, 8'h77);
    tx_data = 8'h55; tx_valid = 1'b1;
    push(1'b0, 4'b0001, 32'h0);
    push(1'b0, 4'b1000, 32'h0);
    push(1'b1, 4'b0100, 32'h0055_0000);
    drain(100);
    exp_txr++;
    check("prio_txr", txr_cnt, exp_txr);

    // tx_busy set: ISR=03 clears it, and the byte follows the RBR read
    tx_data = 8'h66;
    raise_irq(8'h03, 8'h88);
    push(1'b0, 4'b0001, 32'h0);
    push(1'b0, 4'b1000, 32'h0);
    push(1'b1, 4'b0100, 32'h0066_0000);
    drain(100);
    exp_txr++;
    check("isr03_txr", txr_cnt, exp_txr);
    check("isr03_rx", {24'b0, rx_data}, 32'h88);
    tx_valid = 1'b0;
    rx_ready = 1'b0;

    // Overrun: two loads with nobody taking
    raise_irq(8'h02, 8'h11);
    push(1'b0, 4'b0001, 32'h0);
    push(1'b0, 4'b1000, 32'h0);
    drain(80);
    raise_irq(8'h02, 8'h22);
    push(1'b0, 4'b0001, 32'h0);
    push(1'b0, 4'b1000, 32'h0);
    drain(80);
    check("ovr_data", {24'b0, rx_data}, 32'h22);
    check("ovr_valid", {31'b0, rx_valid}, 1);
    check("ovr_flag", {31'b0, rx_overrun_o}, 1);

    // Ack timeout on a THR write, then a normal retry
    raise_irq(8'h01, 8'h00);
    push(1'b0, 4'b0001, 32'h0);
    drain(50);
    check("pre_to_err", {31'b0, bus_err_o}, 0);
    mute = 1'b1;
    tx_data = 8'h99; tx_valid = 1'b1;
    n = 0;
    while (!stb_o && n < 20) begin @(negedge clk_i); n++; end
    check("to_start", {31'b0, stb_o}, 1);
    len = 0;
    while (stb_o && len < 50) begin @(negedge clk_i); len++; end
    check("to_len", len, 8);
    check("to_err", {31'b0, bus_err_o}, 1);
    check("to_txr", txr_cnt, exp_txr);
    check("to_rx", {24'b0, rx_data}, 32'h22);
    mute = 1'b0;
    push(1'b1, 4'b0100, 32'h0099_0000);
    drain(50);
    exp_txr++;
    check("retry_txr", txr_cnt, exp_txr);
    tx_valid = 1'b0;

    // Reset during a cycle drops the bus at once and restarts at INIT
    mute = 1'b1;
    raise_irq(8'h01, 8'h00);
    n = 0;
    while (!stb_o && n < 20) begin @(negedge clk_i); n++; end
    check("mid_start", {31'b0, stb_o}, 1);
    rst_ni = 1'b0;
    #1;
    check("mid_cyc", {30'b0, cyc_o, stb_o}, 0);
    check("mid_flags", {30'b0, bus_err_o, rx_overrun_o}, 0);
    check("mid_rx", {23'b0, rx_valid, rx_data}, 0);
    check("mid_bus", {27'b0, we_o, sel_o}, 0);
    isr_m = 8'h00; irq_i = 1'b0; mute = 1'b0;
    push(1'b1, 4'b0010, 32'h0000_0300);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
